// File: rtl/uart_rx_framed.sv
// uart_rx_framed: 8N1 UART receiver with a two-flop synchroniser, mid-bit
// sampling, a one-cycle data-valid strobe and a one-cycle framing-error strobe.
// o_Rx_Byte[0] holds the first data bit seen on the line.
`timescale 1ns/100ps
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [0:7] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_q, rx_d;
  logic [1:0]    flush_q, flush_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    index_q, index_d;
  logic [0:7]    shift_q, shift_d;
  logic [0:7]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic          active_q, active_d;

  // Next-state logic: synchroniser, frame sequencing and output strobes.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    sync1_d  = i_Rx_Serial;
    rx_d     = sync1_q;
    flush_d  = {flush_q[0], 1'b1};

    unique case (state_q)
      S_WAIT_IDLE: begin
        count_d = '0;
        index_d = '0;
        // The synchroniser resets to 1, so its stale contents must be flushed
        // before a high rx_q is trusted; otherwise a line held low across
        // reset release would be taken for a start bit.
        if (rx_q && flush_q[1]) state_d = S_IDLE;
      end
      S_IDLE: begin
        count_d = '0;
        index_d = '0;
        if (!rx_q) state_d = S_START;
      end
      S_START: begin
        if (count_q != HALF_C) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          state_d = rx_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (count_q != LAST_C) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d          = '0;
          shift_d[index_q] = rx_q;
          if (index_q != 3'd7) begin
            index_d = index_q + 3'd1;
          end else begin
            index_d = '0;
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (count_q != LAST_C) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          if (rx_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        count_d = '0;
        index_d = '0;
        state_d = S_WAIT_IDLE;
      end
    endcase

    active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_WAIT_IDLE;
      sync1_q  <= 1'b1;
      rx_q     <= 1'b1;
      flush_q  <= '0;
      count_q  <= '0;
      index_q  <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      rx_q     <= rx_d;
      flush_q  <= flush_d;
      count_q  <= count_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed with CLKS_PER_BIT=16 (10 ns clock,
// 160 ns bit time). A negedge monitor logs strobes and received bytes;
// the main sequence checks those logs against hand-computed values.
`timescale 1ns/100ps
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [0:7] rx_byte;
  logic       active;
  logic       ferr;

  int checks = 0;
  int errors = 0;

  // monitor state
  int         cyc = 0;
  int         dv_cnt = 0;
  int         err_cnt = 0;
  int         act_total = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         overlap_cnt = 0;
  int         byte_bad = 0;
  logic       dv_prev = 1'b0;
  logic       err_prev = 1'b0;
  logic [0:7] prev_byte = '0;
  logic [0:7] rx_log [64];
  int         dv_cyc [64];

  uart_rx_framed #(.CLKS_PER_BIT(16)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Active    (active),
    .o_Rx_Frame_Err (ferr)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle and log strobes, bytes and protocol violations.
  always @(negedge clk) begin
    if (dv) begin
      if (dv_cnt < 64) begin
        rx_log[dv_cnt] = rx_byte;
        dv_cyc[dv_cnt] = cyc;
      end
      dv_cnt = dv_cnt + 1;
    end
    if (ferr) err_cnt = err_cnt + 1;
    if (dv && ferr) both_cnt = both_cnt + 1;
    if ((dv && dv_prev) || (ferr && err_prev)) long_cnt = long_cnt + 1;
    if (dv && active) overlap_cnt = overlap_cnt + 1;
    if (active) act_total = act_total + 1;
    if (!rst && !dv && (rx_byte !== prev_byte)) byte_bad = byte_bad + 1;
    prev_byte = rx_byte;
    dv_prev   = dv;
    err_prev  = ferr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Align to 1 ns after a rising edge.
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Start bit, bits[0] first through bits[7], then the given stop level.
  task automatic send_frame(input logic [0:7] bits, input int bt, input logic stop_bit);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = bits[i];
      #(bt);
    end
    rx = stop_bit;
    #(bt);
  endtask

  int n0, e0, a0, c0, lat;

  initial begin
    // reset state
    rst = 1'b1;
    rx  = 1'b1;
    #30;
    check("reset_dv",     dv,      1'b0);
    check("reset_err",    ferr,    1'b0);
    check("reset_active", active,  1'b0);
    check("reset_byte",   rx_byte, 8'h00);
    align();
    rst = 1'b0;
    #200;

    // 1: single frame, line bits 1,0,1,0,0,1,0,1
    n0 = dv_cnt; e0 = err_cnt;
    align();
    c0 = cyc;
    send_frame(8'b10100101, 160, 1'b1);
    #320;
    check("t1_dv_count",  dv_cnt - n0,  1);
    check("t1_byte",      rx_log[n0],   8'b10100101);
    check("t1_out_byte",  rx_byte,      8'b10100101);
    check("t1_err_count", err_cnt - e0, 0);
    lat = dv_cyc[n0] - c0;
    check("t1_latency_in_154_156", (lat >= 154) && (lat <= 156), 1'b1);

    // 2: 3-clock low glitch on idle line
    n0 = dv_cnt; e0 = err_cnt; a0 = act_total;
    align();
    rx = 1'b0;
    #30;
    rx = 1'b1;
    #400;
    check("t2_active_seen",  (act_total - a0) > 0,   1'b1);
    check("t2_active_le_10", (act_total - a0) <= 10, 1'b1);
    check("t2_active_now",   active,                 1'b0);
    check("t2_dv_count",     dv_cnt - n0,            0);
    check("t2_err_count",    err_cnt - e0,           0);
    check("t2_byte_held",    rx_byte,                8'b10100101);

    // 3: 0x00 frame with low stop, line held low 40 bit times
    n0 = dv_cnt; e0 = err_cnt;
    align();
    rx = 1'b0;
    #(40 * 160);
    check("t3_err_count",  err_cnt - e0, 1);
    check("t3_dv_count",   dv_cnt - n0,  0);
    check("t3_active_low", active,       1'b0);
    check("t3_byte_held",  rx_byte,      8'b10100101);
    rx = 1'b1;
    #320;
    check("t3_err_after_high", err_cnt - e0, 1);
    align();
    send_frame(8'hFF, 160, 1'b1);
    #320;
    check("t3_ff_dv_count", dv_cnt - n0,  1);
    check("t3_ff_byte",     rx_log[n0],   8'hFF);
    check("t3_ff_err",      err_cnt - e0, 1);

    // 4: back-to-back frames, nominal and +3% bit period
    n0 = dv_cnt; e0 = err_cnt;
    align();
    send_frame(8'h55, 160, 1'b1);
    send_frame(8'hAA, 160, 1'b1);
    send_frame(8'h0F, 160, 1'b1);
    #320;
    check("t4a_dv_count", dv_cnt - n0,    3);
    check("t4a_byte0",    rx_log[n0],     8'h55);
    check("t4a_byte1",    rx_log[n0 + 1], 8'hAA);
    check("t4a_byte2",    rx_log[n0 + 2], 8'h0F);
    check("t4a_err",      err_cnt - e0,   0);
    n0 = dv_cnt;
    align();
    send_frame(8'h55, 165, 1'b1);
    send_frame(8'hAA, 165, 1'b1);
    send_frame(8'h0F, 165, 1'b1);
    #320;
    check("t4b_dv_count", dv_cnt - n0,    3);
    check("t4b_byte0",    rx_log[n0],     8'h55);
    check("t4b_byte1",    rx_log[n0 + 1], 8'hAA);
    check("t4b_byte2",    rx_log[n0 + 2], 8'h0F);
    check("t4b_err",      err_cnt - e0,   0);

    // 5: reset during data bit 4 (line low), then 0x3C
    n0 = dv_cnt; e0 = err_cnt;
    align();
    fork
      send_frame(8'b11110000, 160, 1'b1);
      begin
        #(5 * 160 + 80);
        check("t5_active_before_rst", active, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_active", active,  1'b0);
        check("t5_rst_dv",     dv,      1'b0);
        check("t5_rst_err",    ferr,    1'b0);
        check("t5_rst_byte",   rx_byte, 8'h00);
        #20;
        rst = 1'b0;
      end
    join
    #480;
    check("t5_abort_dv",  dv_cnt - n0,  0);
    check("t5_abort_err", err_cnt - e0, 0);
    align();
    send_frame(8'b00111100, 160, 1'b1);
    #320;
    check("t5_dv_count", dv_cnt - n0,  1);
    check("t5_byte",     rx_log[n0],   8'b00111100);
    check("t5_err",      err_cnt - e0, 0);

    // 6: reset released while line held low
    n0 = dv_cnt; e0 = err_cnt;
    align();
    rst = 1'b1;
    rx  = 1'b0;
    #30;
    align();
    rst = 1'b0;
    a0 = act_total;
    #(5 * 160);
    check("t6_active_total", act_total - a0, 0);
    check("t6_dv_count",     dv_cnt - n0,    0);
    check("t6_err_count",    err_cnt - e0,   0);
    rx = 1'b1;
    #320;
    check("t6_active_after", act_total - a0, 0);
    check("t6_dv_after",     dv_cnt - n0,    0);

    // global protocol properties
    check("dv_and_err_together", both_cnt,    0);
    check("strobe_longer_1clk",  long_cnt,    0);
    check("dv_while_active",     overlap_cnt, 0);
    check("byte_changed_no_dv",  byte_bad,    0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
